// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM encoding and default widths for the pipeline controller.
package pipeline_ctrl_pkg;
  localparam int REG_IDX_W = 4;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator; register 0 never hazards.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = REG_IDX_W
) (
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  input  logic [W-1:0] rd,
  input  logic         use_rs1,
  input  logic         use_rs2,
  input  logic         is_load,
  input  logic         wr_reg,
  output logic         hazard
);
  assign hazard = is_load && wr_reg && rd != '0 &&
                  ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller resolving memory waits, EX redirects and load-use hazards.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = REG_IDX_W,
  parameter int MEM_TIMEOUT         = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs2,
  input  logic                           id_use_rs1,
  input  logic                           id_use_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
  input  logic                           ex_wrReg,
  input  logic                           ex_is_load,
  input  logic                           ex_redirect,
  input  logic                           me_mem_access,
  input  logic                           mem_ack,
  output logic                           mem_req,
  output logic                           pc_wrt_en,
  output logic                           ifid_wrt_en,
  output logic                           idex_wrt_en,
  output logic                           exme_wrt_en,
  output logic                           memwb_wrt_en,
  output logic                           ifid_flush,
  output logic                           idex_flush,
  output logic                           memwb_flush,
  output logic                           mem_err,
  output logic [31:0]                    stall_cycles,
  output logic [15:0]                    flush_count
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          hazard, timeout, freeze, redirect, load_use;
  hazard_detect #(.W(REG_INDEX_BIT_WIDTH)) u_hazard (
    .rs1(id_rs1), .rs2(id_rs2), .rd(ex_rd), .use_rs1(id_use_rs1), .use_rs2(id_use_rs2),
    .is_load(ex_is_load), .wr_reg(ex_wrReg), .hazard(hazard)
  );
  assign timeout  = state == MEM_WAIT && wait_cnt == CW'(MEM_TIMEOUT) && !mem_ack;
  assign freeze   = reset && (state == MEM_WAIT ? !mem_ack && !timeout : me_mem_access && !mem_ack);
  assign redirect = reset && !freeze && ex_redirect;
  // The release cycle out of MEM_WAIT honours a held redirect but never load-use.
  assign load_use = reset && state == RUN && !freeze && !ex_redirect && hazard;
  assign mem_req      = reset && (state == MEM_WAIT || me_mem_access);
  assign pc_wrt_en    = reset && !freeze && !load_use;
  assign ifid_wrt_en  = pc_wrt_en;
  assign idex_wrt_en  = reset && !freeze;
  assign exme_wrt_en  = idex_wrt_en;
  assign memwb_wrt_en = idex_wrt_en;
  assign ifid_flush   = redirect;
  assign idex_flush   = redirect || load_use;
  assign memwb_flush  = freeze;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state        <= freeze ? MEM_WAIT : RUN;
      wait_cnt     <= (state == MEM_WAIT && freeze) ? wait_cnt + 1'b1 : '0;
      mem_err      <= mem_err || timeout;
      stall_cycles <= (!pc_wrt_en && stall_cycles != '1) ? stall_cycles + 1'b1 : stall_cycles;
      flush_count  <= (redirect && flush_count != '1) ? flush_count + 1'b1 : flush_count;
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  localparam logic [8:0] C_RST    = 9'b0_00000_000;
  localparam logic [8:0] C_NORM   = 9'b0_11111_000;
  localparam logic [8:0] C_LU     = 9'b0_00111_010;
  localparam logic [8:0] C_REDIR  = 9'b0_11111_110;
  localparam logic [8:0] C_FRZ    = 9'b1_00000_001;
  localparam logic [8:0] C_REL    = 9'b1_11111_000;
  localparam logic [8:0] C_REL_RD = 9'b1_11111_110;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_wrReg = 0, ex_is_load = 0, ex_redirect = 0;
  logic me_mem_access = 0, mem_ack = 0;
  logic mem_req, pc_wrt_en, ifid_wrt_en, idex_wrt_en, exme_wrt_en, memwb_wrt_en;
  logic ifid_flush, idex_flush, memwb_flush, mem_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [8:0] ctrl;
  int checks = 0, failures = 0;
  pipeline_ctrl #(.REG_INDEX_BIT_WIDTH(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_wrReg(ex_wrReg), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .me_mem_access(me_mem_access), .mem_ack(mem_ack),
    .mem_req(mem_req), .pc_wrt_en(pc_wrt_en), .ifid_wrt_en(ifid_wrt_en),
    .idex_wrt_en(idex_wrt_en), .exme_wrt_en(exme_wrt_en), .memwb_wrt_en(memwb_wrt_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  assign ctrl = {mem_req, pc_wrt_en, ifid_wrt_en, idex_wrt_en, exme_wrt_en, memwb_wrt_en,
                 ifid_flush, idex_flush, memwb_flush};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {id_use_rs1, id_use_rs2, ex_wrReg, ex_is_load, ex_redirect, me_mem_access, mem_ack} = '0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
  endtask
  task automatic set_lu();
    ex_is_load = 1; ex_wrReg = 1; ex_rd = 4'd5; id_use_rs1 = 1; id_rs1 = 4'd5;
  endtask
  initial begin
    ex_redirect = 1; me_mem_access = 1; set_lu();
    #2;
    chk("reset_ctrl", 32'(ctrl), 32'(C_RST));
    chk("reset_stall", stall_cycles, 0);
    chk("reset_flush", 32'(flush_count), 0);
    chk("reset_err", 32'(mem_err), 0);
    clear();
    cyc();
    reset = 1;
    #1 chk("idle", 32'(ctrl), 32'(C_NORM));
    set_lu();
    #1 chk("lu_rs1", 32'(ctrl), 32'(C_LU));
    cyc();
    chk("lu_stall1", stall_cycles, 1);
    ex_rd = 4'd0; id_rs1 = 4'd0;
    #1 chk("lu_r0", 32'(ctrl), 32'(C_NORM));
    ex_rd = 4'd5; id_rs1 = 4'd5; id_use_rs1 = 0;
    #1 chk("lu_nouse", 32'(ctrl), 32'(C_NORM));
    ex_is_load = 0; id_use_rs1 = 1;
    #1 chk("lu_notload", 32'(ctrl), 32'(C_NORM));
    cyc();
    chk("lu_stall_hold", stall_cycles, 1);
    ex_is_load = 1; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 4'd5;
    #1 chk("lu_rs2", 32'(ctrl), 32'(C_LU));
    cyc();
    chk("lu_stall2", stall_cycles, 2);
    clear(); set_lu(); ex_redirect = 1;
    #1 chk("redir_lu", 32'(ctrl), 32'(C_REDIR));
    cyc();
    chk("redir_fc", 32'(flush_count), 1);
    chk("redir_stall", stall_cycles, 2);
    clear(); me_mem_access = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
      cyc();
    end
    mem_ack = 1;
    #1 chk("mw_rel", 32'(ctrl), 32'(C_REL));
    cyc();
    clear();
    #1 chk("mw_after", 32'(ctrl), 32'(C_NORM));
    chk("mw_stall", stall_cycles, 5);
    chk("mw_err", 32'(mem_err), 0);
    me_mem_access = 1; mem_ack = 1;
    #1 chk("mw_same_ack", 32'(ctrl), 32'(C_REL));
    cyc();
    chk("mw_same_stall", stall_cycles, 5);
    clear(); me_mem_access = 1; ex_redirect = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("sim_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
      cyc();
    end
    mem_ack = 1;
    #1 chk("sim_rel", 32'(ctrl), 32'(C_REL_RD));
    cyc();
    chk("sim_fc", 32'(flush_count), 2);
    chk("sim_stall", stall_cycles, 7);
    clear(); me_mem_access = 1;
    for (int i = 0; i < 16; i++) begin
      #1 chk($sformatf("to_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
      cyc();
    end
    #1 chk("to_rel", 32'(ctrl), 32'(C_REL));
    chk("to_err_pre", 32'(mem_err), 0);
    cyc();
    clear();
    chk("to_err", 32'(mem_err), 1);
    chk("to_stall", stall_cycles, 23);
    #1 chk("to_after", 32'(ctrl), 32'(C_NORM));
    cyc();
    chk("to_err_sticky", 32'(mem_err), 1);
    me_mem_access = 1;
    cyc();
    cyc();
    chk("rst_pre", 32'(ctrl), 32'(C_FRZ));
    chk("rst_pre_stall", stall_cycles, 25);
    reset = 0;
    #1 chk("rst_async", 32'(ctrl), 32'(C_RST));
    chk("rst_stall", stall_cycles, 0);
    chk("rst_fc", 32'(flush_count), 0);
    chk("rst_err", 32'(mem_err), 0);
    clear();
    cyc();
    reset = 1;
    #1 chk("rst_run", 32'(ctrl), 32'(C_NORM));
    cyc();
    chk("rst_stall_after", stall_cycles, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. Drives the `wrt_en` and bubble-insert (flush) controls of the PC, IF/ID, ID/EX, EX/ME and ME/WB pipeline registers. It resolves three events:
- load-use hazards;
- EX-stage control redirects;
- multi-cycle data-memory accesses, via a req/ack handshake with timeout.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- REG_INDEX_BIT_WIDTH, 4, width of register indices
- MEM_TIMEOUT, 15, maximum ME wait cycles before forced release (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_INDEX_BIT_WIDTH  source indices of instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  REG_INDEX_BIT_WIDTH  destination of instruction in EX
- ex_wrReg  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load (ME mux selects memory data)
- ex_redirect  in  1  branch taken / jump resolved in EX; PC input holds target
- me_mem_access  in  1  ME instruction is a load or store
- mem_ack  in  1  data memory completes the current access this cycle
- mem_req  out  1  data memory request
- pc_wrt_en, ifid_wrt_en, idex_wrt_en, exme_wrt_en, memwb_wrt_en  out  1 each  pipeline register write enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all-zero control) into that register this cycle
- mem_err  out  1  sticky: a memory access timed out
- stall_cycles  out  32  saturating count of cycles with pc_wrt_en = 0
- flush_count  out  16  saturating count of redirects taken

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Priority when events coincide: memory stall > redirect > load-use.
- RUN with me_mem_access:
  - mem_req = 1.
  - mem_ack = 1 same cycle: no stall; continue evaluating redirect and load-use.
  - mem_ack = 0: freeze this cycle and go to MEM_WAIT. Freeze means all wrt_en = 0, memwb_flush = 1, other flushes = 0.
- MEM_WAIT:
  - mem_req held at 1; freeze held; wait counter increments.
  - On mem_ack: all enables = 1 that cycle, go to RUN.
  - When the counter reaches MEM_TIMEOUT without ack: set mem_err, release exactly as on ack, go to RUN.
- Redirect (RUN, no memory stall, ex_redirect = 1):
  - all wrt_en = 1; ifid_flush = 1, idex_flush = 1; flush_count += 1.
  - Load-use is ignored in this cycle, because the ID instruction is being squashed.
- Load-use (RUN, no memory stall, no redirect):
  - Hazard = ex_is_load & ex_wrReg & ex_rd ≠ 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Response: pc_wrt_en = 0, ifid_wrt_en = 0, idex_wrt_en = 1 with idex_flush = 1; exme_wrt_en = 1, memwb_wrt_en = 1.
  - Register 0 never creates a hazard. ME→EX forwarding covers the following cycle.
- Otherwise all wrt_en = 1 and all flushes = 0.
- A redirect that arrives during a memory stall is not lost: EX is frozen, so ex_redirect stays asserted and is acted on in the release cycle.
- Counters saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from state and inputs. State, wait counter, mem_err and the perf counters are registered.
- While reset is asserted (reset = 0), outputs are forced regardless of inputs:
  - all wrt_en = 0, all flushes = 0, mem_req = 0.
  - mem_err = 0, stall_cycles = 0, flush_count = 0.
  - wait counter = 0, state = RUN.
- Reset mid-MEM_WAIT returns to RUN immediately; mem_req drops asynchronously.
- Penalties:
  - load-use: 1 bubble;
  - redirect: 2 bubbles;
  - memory access with ack N cycles after request: N frozen cycles (0 if same-cycle ack);
  - timeout: MEM_TIMEOUT + 1 frozen cycles.
- The wait counter is $clog2(MEM_TIMEOUT+1) bits wide and clears on every exit from MEM_WAIT.

## Structure
- Shared package/header `pipeline_ctrl_pkg`:
  - FSM state encoding (RUN = 0, MEM_WAIT = 1);
  - the REG_INDEX_BIT_WIDTH default.
- One sub-module, `hazard_detect`: purely combinational load-use comparator returning a 1-bit hazard flag.
- Counters and state use the existing Register primitive or equivalent always blocks.

## Test plan
- Load-use: ex_is_load = 1, ex_wrReg = 1, ex_rd = 5, id_use_rs1 = 1, id_rs1 = 5 → one cycle with pc_wrt_en = 0, ifid_wrt_en = 0, idex_flush = 1, exme_wrt_en = 1; stall_cycles = 1. Same stimulus with ex_rd = 0, or with id_use_rs1 = 0 → no stall.
- Redirect: ex_redirect = 1 together with a load-use match → ifid_flush = 1, idex_flush = 1, all wrt_en = 1; flush_count = 1; stall_cycles unchanged.
- Memory wait: me_mem_access = 1 with mem_ack arriving 3 cycles later → mem_req high 4 cycles, 3 frozen cycles with memwb_flush = 1, release on cycle 4; stall_cycles = 3. Same-cycle ack → 0 stalls.
- Timeout: MEM_TIMEOUT = 15, mem_ack never asserted → 16 frozen cycles, then release; mem_err = 1 and stays 1 until reset.
- Simultaneous events: ex_redirect held during a 2-cycle memory wait → no flushes while frozen; ifid_flush and idex_flush asserted in the release cycle; flush_count increments exactly once.
- Reset: drive reset = 0 asynchronously mid-MEM_WAIT → mem_req and all wrt_en drop to 0 before the next clock edge; after release, state is RUN and all counters are 0.
